// File: rtl/multi_channel_pulse_detector_if.sv
// Bundle of the per-channel pulse detector signals.
//   en, a              : per-channel enable and synchronised inputs
//   min_len, max_len   : shared accepted pulse-length window
//   rise_det, fall_det : per-channel edge flags
//   pulse_det          : per-channel accepted-pulse flags
//   long_det           : per-channel over-long-pulse flags
//   any_pulse          : OR of pulse_det
// master drives the inputs and watches the flags; slave is the detector.
interface multi_channel_pulse_detector_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  a;
  logic [CNT_W-1:0] min_len;
  logic [CNT_W-1:0] max_len;
  logic [N_CH-1:0]  rise_det;
  logic [N_CH-1:0]  fall_det;
  logic [N_CH-1:0]  pulse_det;
  logic [N_CH-1:0]  long_det;
  logic             any_pulse;

  modport master (
    output en, a, min_len, max_len,
    input  rise_det, fall_det, pulse_det, long_det, any_pulse
  );

  modport slave (
    input  en, a, min_len, max_len,
    output rise_det, fall_det, pulse_det, long_det, any_pulse
  );
endinterface

// File: rtl/multi_channel_pulse_detector.sv
// N independent channels, each flagging rising/falling edges of its input and
// classifying completed high pulses by length against a shared [min_len,max_len]
// window. Classification is Mealy: flags assert in the cycle the input is first
// seen low after the pulse, coincident with fall_det.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset; all flags forced low while asserted
//   bus  : slave side of multi_channel_pulse_detector_if (en, a, min_len,
//          max_len in; rise_det, fall_det, pulse_det, long_det, any_pulse out)
module multi_channel_pulse_detector #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  multi_channel_pulse_detector_if.slave bus
);

  typedef enum logic [1:0] {ARM, LOW, HIGH, LONG} state_t;

  state_t           state     [N_CH];
  state_t           state_nxt [N_CH];
  logic [CNT_W-1:0] cnt       [N_CH];
  logic [CNT_W-1:0] cnt_nxt   [N_CH];
  logic [N_CH-1:0]  a_r;
  logic [N_CH-1:0]  pulse_raw;
  logic [N_CH-1:0]  long_raw;
  logic [N_CH-1:0]  live;

  // A zero minimum means "any non-empty pulse"; a pulse is at least one cycle.
  function automatic logic [CNT_W-1:0] eff_min(input logic [CNT_W-1:0] m);
    return (m == '0) ? CNT_W'(1) : m;
  endfunction

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      pulse_raw[i] = 1'b0;
      long_raw[i]  = 1'b0;
      case (state[i])
        // A pulse already high at reset/enable is skipped until the line drops.
        ARM:  if (!bus.a[i]) state_nxt[i] = LOW;
        LOW: begin
          if (bus.a[i]) begin
            if (bus.max_len == '0) begin
              state_nxt[i] = LONG;
            end else begin
              state_nxt[i] = HIGH;
              cnt_nxt[i]   = CNT_W'(1);
            end
          end
        end
        HIGH: begin
          if (bus.a[i]) begin
            // Saturate into LONG instead of counting past max_len, so the
            // counter can never wrap even at max_len = all-ones.
            if (cnt[i] >= bus.max_len) state_nxt[i] = LONG;
            else                       cnt_nxt[i]   = cnt[i] + CNT_W'(1);
          end else begin
            pulse_raw[i] = (cnt[i] >= eff_min(bus.min_len));
            state_nxt[i] = LOW;
          end
        end
        LONG: begin
          if (!bus.a[i]) begin
            long_raw[i]  = 1'b1;
            state_nxt[i] = LOW;
          end
        end
        default: state_nxt[i] = ARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst || !bus.en[i]) begin
        state[i] <= ARM;
        cnt[i]   <= '0;
        a_r[i]   <= 1'b0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        a_r[i]   <= bus.a[i];
      end
    end
  end

  // Output gating: reset and per-channel enable mask every flag combinationally.
  assign live          = rst ? '0 : bus.en;
  assign bus.rise_det  = live & ~a_r & bus.a;
  assign bus.fall_det  = live & a_r & ~bus.a;
  assign bus.pulse_det = live & pulse_raw;
  assign bus.long_det  = live & long_raw;
  assign bus.any_pulse = |bus.pulse_det;

endmodule
